// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampling UART receiver with parity, 1/2 stop bits, false-start rejection,
// error flags and a one-frame valid/ready holding register. Optional: UART_RX_MAJORITY_VOTE_EN.
`timescale 1ns/1ps
module uart_rx_framed #(
  parameter int CLK_FREQ    = 5000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_uart_rx,
  input  logic                 i_ready,
  input  logic                 i_overrun_clr,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int MID   = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int DEC   = MID + 1;
`else
  localparam int DEC   = MID;
`endif
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  SAMP_DEC  = OS_W'(DEC);
  localparam logic [OS_W-1:0]  SAMP_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY_MODE == 2) ? 1'b1 : 1'b0;

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_framed: OVERSAMPLE must be even and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_rx_framed: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_pm
    $error("uart_rx_framed: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
    $error("uart_rx_framed: STOP_BITS must be 1 or 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_framed: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

  function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  logic [DIV_W-1:0]     tick_cnt_q;
  logic                 tick_s;
  logic                 sync1_q, sync2_q, rx_s, bit_s;
  state_e               state_q, state_d;
  logic [OS_W-1:0]      samp_q, samp_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pbad_q, pbad_d, fbad_q, fbad_d;
  logic                 done_s, load_s, drop_s;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d, busy_q;

  assign tick_s = (tick_cnt_q == DIV_LAST);
  assign rx_s   = sync2_q;

  // Baud-rate x OVERSAMPLE tick divider
  always_ff @(posedge clk) begin
    if (reset || tick_s) tick_cnt_q <= {DIV_W{1'b0}};
    else                 tick_cnt_q <= tick_cnt_q + DIV_W'(1);
  end

  // Two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  function automatic logic maj3_f(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0] hist_q;

  // History of the two previous tick samples for the 2-of-3 vote
  always_ff @(posedge clk) begin
    if (reset)       hist_q <= 2'b11;
    else if (tick_s) hist_q <= {hist_q[0], rx_s};
    else             hist_q <= hist_q;
  end

  assign bit_s = maj3_f(hist_q[1], hist_q[0], rx_s);
`else
  assign bit_s = rx_s;
`endif

  // Receive FSM and datapath state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      samp_q  <= {OS_W{1'b0}};
      bit_q   <= 4'd0;
      shreg_q <= {DATA_BITS{1'b0}};
      pbad_q  <= 1'b0;
      fbad_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pbad_q  <= pbad_d;
      fbad_q  <= fbad_d;
    end
  end

  // Next-state logic; everything advances on a tick only
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pbad_d  = pbad_q;
    fbad_d  = fbad_q;
    done_s  = 1'b0;
    if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            samp_d  = {OS_W{1'b0}};
            bit_d   = 4'd0;
            pbad_d  = 1'b0;
            fbad_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (samp_q == SAMP_DEC && bit_s) begin
            state_d = ST_IDLE;              // false start: line back high mid-bit
            samp_d  = {OS_W{1'b0}};
          end else if (samp_q == SAMP_LAST) begin
            state_d = ST_DATA;
            samp_d  = {OS_W{1'b0}};
          end else begin
            samp_d  = samp_q + OS_W'(1);
          end
        end
        ST_DATA: begin
          if (samp_q == SAMP_DEC) begin
            shreg_d = {bit_s, shreg_q[DATA_BITS-1:1]};
          end else begin
            shreg_d = shreg_q;
          end
          if (samp_q == SAMP_LAST) begin
            samp_d = {OS_W{1'b0}};
            if (bit_q == DATA_LAST) begin
              bit_d   = 4'd0;
              state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_d   = bit_q + 4'd1;
            end
          end else begin
            samp_d = samp_q + OS_W'(1);
          end
        end
        ST_PARITY: begin
          if (samp_q == SAMP_DEC) begin
            pbad_d = parity_f(shreg_q) ^ bit_s ^ ODD_PAR;
          end else begin
            pbad_d = pbad_q;
          end
          if (samp_q == SAMP_LAST) begin
            state_d = ST_STOP;
            samp_d  = {OS_W{1'b0}};
          end else begin
            samp_d  = samp_q + OS_W'(1);
          end
        end
        ST_STOP: begin
          if (samp_q == SAMP_DEC) begin
            fbad_d = fbad_q | ~bit_s;
            if (bit_q == STOP_LAST) begin
              done_s  = 1'b1;               // complete mid-bit to regain half a bit of margin
              state_d = ST_IDLE;
              samp_d  = {OS_W{1'b0}};
            end else begin
              samp_d  = samp_q + OS_W'(1);
            end
          end else if (samp_q == SAMP_LAST) begin
            bit_d  = bit_q + 4'd1;
            samp_d = {OS_W{1'b0}};
          end else begin
            samp_d = samp_q + OS_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          samp_d  = {OS_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign load_s = done_s && (!valid_q || i_ready);
  assign drop_s = done_s && valid_q && !i_ready;

  // Holding register, handshake and sticky overrun
  always_comb begin
    data_d = data_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    if (load_s) begin
      data_d  = shreg_q;
      perr_d  = pbad_q;
      ferr_d  = fbad_d;
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (drop_s)             ovr_d = 1'b1;
    else if (i_overrun_clr) ovr_d = 1'b0;
    else                    ovr_d = ovr_q;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= {DATA_BITS{1'b0}};
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: an 8N1 instance and an 8E1 instance driven by directed frames.
`timescale 1ns/1ps
module tb_uart_rx_framed;
  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0, reset = 1'b1, clr = 1'b0;
  logic       rx_n = 1'b1, ready_n = 1'b0, rx_p = 1'b1, ready_p = 1'b0;
  logic [7:0] o_data_n, o_data_p;
  logic       o_valid_n, o_perr_n, o_ferr_n, o_ovr_n, o_busy_n;
  logic       o_valid_p, o_perr_p, o_ferr_p, o_ovr_p, o_busy_p;

  typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
  exp_t q_n[$];
  exp_t q_p[$];
  exp_t e_n, e_p;
  bit   shown_n = 1'b0, shown_p = 1'b0;
  int   total = 0, passed = 0;

  uart_rx_framed #(.CLK_FREQ(1536000), .BAUD_RATE(9600), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY_MODE(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .reset(reset), .i_uart_rx(rx_n), .i_ready(ready_n), .i_overrun_clr(clr),
    .o_data(o_data_n), .o_valid(o_valid_n), .o_parity_err(o_perr_n), .o_frame_err(o_ferr_n),
    .o_overrun(o_ovr_n), .o_busy(o_busy_n));

  uart_rx_framed #(.CLK_FREQ(1536000), .BAUD_RATE(9600), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY_MODE(1), .STOP_BITS(1)) dut_p (
    .clk(clk), .reset(reset), .i_uart_rx(rx_p), .i_ready(ready_p), .i_overrun_clr(clr),
    .o_data(o_data_p), .o_valid(o_valid_p), .o_parity_err(o_perr_p), .o_frame_err(o_ferr_p),
    .o_overrun(o_ovr_p), .o_busy(o_busy_p));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx_n = v;
  endtask

  // frame is LSB first: start bit in bit 0
  task automatic send_bits(input bit sel, input logic [15:0] frame, input int len, input bit glitch);
    for (int i = 0; i < len; i++) begin
      drive(sel, frame[i]);
      if (glitch) begin
        cyc(80);
        drive(sel, ~frame[i]);
        cyc(10);
        drive(sel, frame[i]);
        cyc(70);
      end else begin
        cyc(BIT_CLKS);
      end
    end
    drive(sel, 1'b1);
  endtask

  task automatic pulse_ready(input bit sel);
    if (sel) ready_p = 1'b1;
    else     ready_n = 1'b1;
    cyc(1);
    ready_p = 1'b0;
    ready_n = 1'b0;
  endtask

  // Monitor: compare each newly presented frame against the scoreboard
  always @(negedge clk) begin
    if (o_valid_n && !shown_n) begin
      shown_n = 1'b1;
      if (q_n.size() == 0) begin
        total++;
        $display("FAIL n_unexpected_frame: got data 0x%0h, expected no frame", o_data_n);
      end else begin
        e_n = q_n.pop_front();
        chk("n_data", 32'(o_data_n), 32'(e_n.d));
        chk("n_parity_err", 32'(o_perr_n), 32'(e_n.pe));
        chk("n_frame_err", 32'(o_ferr_n), 32'(e_n.fe));
      end
    end
    if (!o_valid_n || ready_n) shown_n = 1'b0;
  end

  always @(negedge clk) begin
    if (o_valid_p && !shown_p) begin
      shown_p = 1'b1;
      if (q_p.size() == 0) begin
        total++;
        $display("FAIL p_unexpected_frame: got data 0x%0h, expected no frame", o_data_p);
      end else begin
        e_p = q_p.pop_front();
        chk("p_data", 32'(o_data_p), 32'(e_p.d));
        chk("p_parity_err", 32'(o_perr_p), 32'(e_p.pe));
        chk("p_frame_err", 32'(o_ferr_p), 32'(e_p.fe));
      end
    end
    if (!o_valid_p || ready_p) shown_p = 1'b0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected finish before 900us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cyc(5);
    chk("rst_valid", 32'(o_valid_n), 32'd0);
    chk("rst_data", 32'(o_data_n), 32'd0);
    chk("rst_perr", 32'(o_perr_n), 32'd0);
    chk("rst_ferr", 32'(o_ferr_n), 32'd0);
    chk("rst_ovr", 32'(o_ovr_n), 32'd0);
    chk("rst_busy", 32'(o_busy_n), 32'd0);
    reset = 1'b0;
    cyc(200);

    // 8N1 0xA5, held until ready
    q_n.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    send_bits(1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0);
    cyc(20);
    chk("a5_valid_held", 32'(o_valid_n), 32'd1);
    pulse_ready(1'b0);
    chk("a5_valid_drop", 32'(o_valid_n), 32'd0);

    // Even parity: 0x03 with wrong then correct parity bit
    q_p.push_back('{d: 8'h03, pe: 1'b1, fe: 1'b0});
    send_bits(1'b1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 1'b0);
    cyc(20);
    chk("par_bad_flag", 32'(o_perr_p), 32'd1);
    pulse_ready(1'b1);
    q_p.push_back('{d: 8'h03, pe: 1'b0, fe: 1'b0});
    send_bits(1'b1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11, 1'b0);
    cyc(20);
    chk("par_ok_valid", 32'(o_valid_p), 32'd1);
    pulse_ready(1'b1);
    chk("par_ok_drop", 32'(o_valid_p), 32'd0);

    // Framing error then a clean frame
    q_n.push_back('{d: 8'h7E, pe: 1'b0, fe: 1'b1});
    send_bits(1'b0, 16'({1'b0, 8'h7E, 1'b0}), 10, 1'b0);
    cyc(320);
    chk("fe_busy_idle", 32'(o_busy_n), 32'd0);
    chk("fe_flag", 32'(o_ferr_n), 32'd1);
    pulse_ready(1'b0);
    q_n.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
    send_bits(1'b0, 16'({1'b1, 8'h5A, 1'b0}), 10, 1'b0);
    cyc(20);
    pulse_ready(1'b0);

    // 48-clk low glitch on idle line
    rx_n = 1'b0;
    cyc(45);
    chk("glitch_busy_during", 32'(o_busy_n), 32'd1);
    cyc(3);
    rx_n = 1'b1;
    cyc(112);
    chk("glitch_busy_after", 32'(o_busy_n), 32'd0);
    chk("glitch_no_valid", 32'(o_valid_n), 32'd0);
    chk("glitch_no_errs", 32'({o_perr_n, o_ferr_n, o_ovr_n}), 32'd0);

    // Overrun: second frame dropped while first is held
    q_n.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send_bits(1'b0, 16'({1'b1, 8'h11, 1'b0}), 10, 1'b0);
    send_bits(1'b0, 16'({1'b1, 8'h22, 1'b0}), 10, 1'b0);
    cyc(20);
    chk("ovr_data_kept", 32'(o_data_n), 32'h11);
    chk("ovr_set", 32'(o_ovr_n), 32'd1);
    pulse_ready(1'b0);
    chk("ovr_valid_drop", 32'(o_valid_n), 32'd0);
    chk("ovr_sticky", 32'(o_ovr_n), 32'd1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("ovr_cleared", 32'(o_ovr_n), 32'd0);

    // Reset during data bit 4
    send_bits(1'b0, 16'({1'b1, 8'h3C, 1'b0}), 5, 1'b0);
    rx_n = 1'b1;
    cyc(80);
    chk("pre_rst_busy", 32'(o_busy_n), 32'd1);
    reset = 1'b1;
    cyc(3);
    chk("mid_rst_outputs", 32'({o_data_n, o_valid_n, o_perr_n, o_ferr_n, o_ovr_n, o_busy_n}), 32'd0);
    reset = 1'b0;
    cyc(400);
    chk("post_rst_idle", 32'(o_busy_n), 32'd0);
    q_n.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
    send_bits(1'b0, 16'({1'b1, 8'h3C, 1'b0}), 10, 1'b0);
    cyc(20);
    chk("post_rst_valid", 32'(o_valid_n), 32'd1);
    pulse_ready(1'b0);
`ifdef UART_RX_MAJORITY_VOTE_EN
    q_n.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
    send_bits(1'b0, 16'({1'b1, 8'h3C, 1'b0}), 10, 1'b1);
    cyc(20);
    chk("vote_valid", 32'(o_valid_n), 32'd1);
    pulse_ready(1'b0);
`endif

    cyc(50);
    chk("n_queue_empty", 32'(q_n.size()), 32'd0);
    chk("p_queue_empty", 32'(q_p.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Parametrised UART receiver, successor to the basic oversampling receiver. Adds configurable parity, 1 or 2 stop bits, a false-start check and a 2-flop input synchroniser. Also adds parity, framing and overrun error reporting and a valid/ready output handshake with a one-frame holding register. It sits between the board RX pin and the debug/loader command unit of the MIPS system.

Parameters:
CLK_FREQ, 5000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate
OVERSAMPLE, 16, sample ticks per bit; even, at least 8
DATA_BITS, 8, payload bits per frame, 5..9, sent LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_uart_rx  in  1  asynchronous serial line; idles high
i_ready  in  1  consumer accepts the held frame
i_overrun_clr  in  1  clears the sticky overrun flag
o_data  out  DATA_BITS  received payload; stable while o_valid=1
o_valid  out  1  a frame is held in the output register
o_parity_err  out  1  parity mismatch for the held frame
o_frame_err  out  1  a stop bit was sampled low for the held frame
o_overrun  out  1  sticky: a completed frame was dropped
o_busy  out  1  FSM not in IDLE

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; it is sampled on the clk rising edge only.
- Reset values: o_data=0, o_valid=0, all error flags=0, o_busy=0, FSM=IDLE. Tick counter and sample counter=0. Both synchroniser flops=1.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division. The counter runs 0..DIV-1 and emits a 1-clk tick when it wraps. The FSM and sample counter advance only on a tick.
- Input sampling: i_uart_rx passes through 2 flops; rx_s is the second flop. MID = OVERSAMPLE/2 - 1. Each bit is sampled at sample count MID.
- IDLE: when a tick sees rx_s=0, go to START with sample count 0.
- START: at MID, if the sample is 1 this is a false start: return to IDLE with no output and no error. Otherwise go to DATA at sample count OVERSAMPLE-1.
- DATA: shift the sample in at MID, LSB first. After DATA_BITS bits, go to PARITY if PARITY_MODE≠0, else to STOP.
- PARITY: at MID, parity_bad = XOR(payload, parity sample) XOR (PARITY_MODE==2). Go to STOP at OVERSAMPLE-1.
- STOP: at MID of each stop bit, a sample of 0 sets frame_bad.
  - At MID of the last stop bit, the frame completes and the FSM returns to IDLE immediately (half-bit resync margin).
  - Two stop bits: the first advances to the second at OVERSAMPLE-1.
- Frame completion timing: o_valid rises on the clk edge after the completing tick.
- Frame load:
  - If o_valid=0, or i_ready=1 in that same cycle, load o_data, o_parity_err and o_frame_err, and set o_valid=1.
  - Otherwise, drop the new frame, keep the held frame, and set o_overrun=1.
- Handshake: the held frame is consumed when o_valid and i_ready are both 1. o_valid drops the next clk unless a new frame loads in that same cycle.
- Overrun flag: o_overrun clears only on reset or i_overrun_clr=1. If set and clear arrive in the same cycle, set wins.
- Reset mid-frame: the partial frame is discarded and the block returns to the reset values above.
- Parameter checks: illegal parameters (OVERSAMPLE odd or <8, DATA_BITS outside 5..9, PARITY_MODE>2, STOP_BITS not 1 or 2) cause an $error at elaboration.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of samples at MID-1, MID and MID+1. Decisions are taken at MID+1, so every FSM step is delayed one tick but stays inside the bit.
- Undefined: single sample at MID, as described above.

Test Plan:
Bench parameters unless noted: CLK_FREQ=1536000, BAUD_RATE=9600, OVERSAMPLE=16, so DIV=10 and one bit = 160 clk.
- 8N1, send 0xA5 with i_ready=0 -> o_valid=1, o_data=0xA5, parity_err=0, frame_err=0. Pulse i_ready -> o_valid=0 on the next clk.
- PARITY_MODE=1, send 0x03 with parity bit 1 -> o_data=0x03, o_parity_err=1. Resend with parity bit 0 -> o_parity_err=0.
- Send 0x7E with stop bit 0, then line high, then 0x5A -> first frame o_frame_err=1; second frame o_data=0x5A, o_frame_err=0.
- 48-clk low glitch on the idle line -> no o_valid, o_busy returns to 0 within 1 bit time, no error flags.
- Send 0x11 then 0x22 with i_ready=0 -> o_data=0x11, o_overrun=1. i_ready=1 -> o_valid=0. i_overrun_clr -> o_overrun=0.
- Assert reset during data bit 4 of a frame -> all outputs 0; next frame 0x3C received with no errors. Repeat with UART_RX_MAJORITY_VOTE_EN defined and a 1-tick glitch at MID of each bit -> 0x3C still received.
